// File: rtl/data_tx.sv
// Packet source for the cloud client: queues connect/mouse/keyboard events and
// frames them as short byte messages for the downstream network transmitter.
module data_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       connect,
    input  logic       mouse_action,
    input  logic [7:0] mouse_data,
    input  logic       keyboard_action,
    input  logic [7:0] keyboard_data,
    input  logic       tx_busy,
    input  logic       tx_payload,
    output logic       tx_start,
    output logic [7:0] tx_data_length,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       payload,
    output logic       online
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StSend  = 2'd3;

    localparam logic [1:0] FrConn  = 2'd0;
    localparam logic [1:0] FrMouse = 2'd1;
    localparam logic [1:0] FrKey   = 2'd2;

    logic [1:0] state;
    logic       pend_c, pend_m, pend_k;
    logic [7:0] mouse_byte, key_byte;
    logic [1:0] frame_type;
    logic [7:0] frame_b1;
    logic [1:0] idx;
    logic [1:0] last_idx;
    logic       launch;

    function automatic logic [7:0] frame_byte(input logic [1:0] ft, input logic [1:0] i,
                                              input logic [7:0] b1);
        logic [7:0] b;
        b = 8'h00;
        unique case (ft)
            FrConn: begin
                if (i == 2'd0)      b = 8'h43;
                else if (i == 2'd1) b = 8'h4F;
                else                b = 8'h4E;
            end
            FrMouse: b = (i == 2'd0) ? 8'h4D : b1;
            default: b = (i == 2'd0) ? 8'h4B : b1;
        endcase
        return b;
    endfunction

    always_comb begin
        launch   = (state == StIdle) && !tx_busy && (pend_c || pend_m || pend_k);
        last_idx = (frame_type == FrConn) ? 2'd3 : 2'd1;
    end

    // A strobe landing on the launch edge re-arms its flag for another frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_c     <= 1'b0;
            pend_m     <= 1'b0;
            pend_k     <= 1'b0;
            mouse_byte <= 8'h00;
            key_byte   <= 8'h00;
        end else begin
            if (connect) begin
                pend_c <= 1'b1;
            end else if (launch && pend_c) begin
                pend_c <= 1'b0;
            end

            if (mouse_action && online) begin
                pend_m     <= 1'b1;
                mouse_byte <= mouse_data;
            end else if (launch && !pend_c && pend_m) begin
                pend_m <= 1'b0;
            end

            if (keyboard_action && online) begin
                pend_k   <= 1'b1;
                key_byte <= keyboard_data;
            end else if (launch && !pend_c && !pend_m) begin
                pend_k <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= StIdle;
            tx_start       <= 1'b0;
            tx_data_length <= 8'h00;
            tx_data        <= 8'h00;
            busy           <= 1'b0;
            payload        <= 1'b0;
            online         <= 1'b0;
            frame_type     <= FrConn;
            frame_b1       <= 8'h00;
            idx            <= 2'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (launch) begin
                        state    <= StStart;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        // Snapshot the data byte so later strobes cannot alter this frame.
                        if (pend_c) begin
                            frame_type     <= FrConn;
                            frame_b1       <= 8'h00;
                            tx_data_length <= 8'd4;
                        end else if (pend_m) begin
                            frame_type     <= FrMouse;
                            frame_b1       <= mouse_byte;
                            tx_data_length <= 8'd2;
                        end else begin
                            frame_type     <= FrKey;
                            frame_b1       <= key_byte;
                            tx_data_length <= 8'd2;
                        end
                    end
                end
                StStart: begin
                    tx_start <= 1'b0;
                    state    <= StWait;
                end
                StWait: begin
                    if (tx_payload) begin
                        state   <= StSend;
                        payload <= 1'b1;
                        idx     <= 2'd0;
                        tx_data <= frame_byte(frame_type, 2'd0, frame_b1);
                    end
                end
                default: begin
                    if (tx_payload) begin
                        if (idx == last_idx) begin
                            state   <= StIdle;
                            payload <= 1'b0;
                            busy    <= 1'b0;
                            tx_data <= 8'h00;
                            if (frame_type == FrConn) online <= 1'b1;
                        end else begin
                            idx     <= idx + 2'd1;
                            tx_data <= frame_byte(frame_type, idx + 2'd1, frame_b1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_tx.sv
// Directed bench for data_tx: frame contents, timing, gating, arbitration, stall and reset.
module tb_data_tx;

    logic       clk;
    logic       reset;
    logic       connect;
    logic       mouse_action;
    logic [7:0] mouse_data;
    logic       keyboard_action;
    logic [7:0] keyboard_data;
    logic       tx_busy;
    logic       tx_payload;
    logic       tx_start;
    logic [7:0] tx_data_length;
    logic [7:0] tx_data;
    logic       busy;
    logic       payload;
    logic       online;

    int n_cmp = 0;
    int n_err = 0;

    data_tx dut (
        .clk             (clk),
        .reset           (reset),
        .connect         (connect),
        .mouse_action    (mouse_action),
        .mouse_data      (mouse_data),
        .keyboard_action (keyboard_action),
        .keyboard_data   (keyboard_data),
        .tx_busy         (tx_busy),
        .tx_payload      (tx_payload),
        .tx_start        (tx_start),
        .tx_data_length  (tx_data_length),
        .tx_data         (tx_data),
        .busy            (busy),
        .payload         (payload),
        .online          (online)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " tx_start"}, {7'd0, tx_start}, 8'h00);
        check({tag, " len"}, tx_data_length, 8'h00);
        check({tag, " tx_data"}, tx_data, 8'h00);
        check({tag, " busy"}, {7'd0, busy}, 8'h00);
        check({tag, " payload"}, {7'd0, payload}, 8'h00);
        check({tag, " online"}, {7'd0, online}, 8'h00);
    endtask

    // Assumes flags are already set and the next edge launches START; tx_payload held high.
    task automatic expect_frame(input string tag, input int len, input logic [7:0] b0,
                                input logic [7:0] b1);
        logic [7:0] exp_b [2];
        exp_b[0] = b0;
        exp_b[1] = b1;
        tick();
        check({tag, " start"}, {7'd0, tx_start}, 8'h01);
        check({tag, " len"}, tx_data_length, len[7:0]);
        check({tag, " busy"}, {7'd0, busy}, 8'h01);
        tick();
        check({tag, " start drop"}, {7'd0, tx_start}, 8'h00);
        for (int i = 0; i < len; i++) begin
            tick();
            check($sformatf("%s byte%0d", tag, i), tx_data, exp_b[i]);
            check($sformatf("%s payload%0d", tag, i), {7'd0, payload}, 8'h01);
        end
        tick();
        check({tag, " end payload"}, {7'd0, payload}, 8'h00);
        check({tag, " end data"}, tx_data, 8'h00);
        check({tag, " end busy"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        logic [7:0] conn_b [4];
        conn_b[0] = 8'h43;
        conn_b[1] = 8'h4F;
        conn_b[2] = 8'h4E;
        conn_b[3] = 8'h4E;

        reset = 1'b0; connect = 1'b0; mouse_action = 1'b0; mouse_data = 8'h00;
        keyboard_action = 1'b0; keyboard_data = 8'h00; tx_busy = 1'b0; tx_payload = 1'b1;

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1 check_all_zero("reset async");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle no start", {7'd0, tx_start}, 8'h00);
        end

        // Mouse strobe while offline is dropped.
        mouse_data = 8'h77;
        mouse_action = 1'b1;
        tick();
        mouse_action = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("offline start", {7'd0, tx_start}, 8'h00);
            check("offline busy", {7'd0, busy}, 8'h00);
        end
        check("offline online", {7'd0, online}, 8'h00);

        // Connect frame with tx_payload held high.
        connect = 1'b1;
        tick();
        connect = 1'b0;
        check("conn pre start", {7'd0, tx_start}, 8'h00);
        tick();
        check("conn start", {7'd0, tx_start}, 8'h01);
        check("conn len", tx_data_length, 8'd4);
        check("conn busy start", {7'd0, busy}, 8'h01);
        tick();
        check("conn start drop", {7'd0, tx_start}, 8'h00);
        check("conn wait payload", {7'd0, payload}, 8'h00);
        check("conn wait busy", {7'd0, busy}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("conn byte%0d", i), tx_data, conn_b[i]);
            check($sformatf("conn payload%0d", i), {7'd0, payload}, 8'h01);
            check($sformatf("conn online%0d", i), {7'd0, online}, 8'h00);
            check($sformatf("conn busy%0d", i), {7'd0, busy}, 8'h01);
        end
        tick();
        check("conn end payload", {7'd0, payload}, 8'h00);
        check("conn end data", tx_data, 8'h00);
        check("conn end busy", {7'd0, busy}, 8'h00);
        check("conn online", {7'd0, online}, 8'h01);
        check("conn len held", tx_data_length, 8'd4);

        // Mouse then keyboard with zero data.
        mouse_data = 8'h00;
        mouse_action = 1'b1;
        tick();
        mouse_action = 1'b0;
        expect_frame("mouse0", 2, 8'h4D, 8'h00);
        keyboard_data = 8'h00;
        keyboard_action = 1'b1;
        tick();
        keyboard_action = 1'b0;
        expect_frame("key0", 2, 8'h4B, 8'h00);
        mouse_data = 8'hA5;
        mouse_action = 1'b1;
        tick();
        mouse_action = 1'b0;
        expect_frame("mouseA5", 2, 8'h4D, 8'hA5);

        // Simultaneous strobes held off by tx_busy, then sent in priority order.
        tx_busy = 1'b1;
        mouse_data = 8'h11;
        keyboard_data = 8'h22;
        mouse_action = 1'b1;
        keyboard_action = 1'b1;
        tick();
        mouse_action = 1'b0;
        keyboard_action = 1'b0;
        mouse_data = 8'h00;
        keyboard_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("txbusy no start", {7'd0, tx_start}, 8'h00);
            check("txbusy idle", {7'd0, busy}, 8'h00);
        end
        tx_busy = 1'b0;
        expect_frame("sim mouse", 2, 8'h4D, 8'h11);
        expect_frame("sim key", 2, 8'h4B, 8'h22);
        tick();
        check("sim drained", {7'd0, tx_start}, 8'h00);

        // Stall after byte 1 of a connect frame, then reset mid-frame.
        connect = 1'b1;
        tick();
        connect = 1'b0;
        tick();
        check("stall start", {7'd0, tx_start}, 8'h01);
        tick();
        tick();
        check("stall byte0", tx_data, 8'h43);
        tick();
        check("stall byte1", tx_data, 8'h4F);
        tx_payload = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall hold", tx_data, 8'h4F);
            check("stall payload", {7'd0, payload}, 8'h01);
        end
        tx_payload = 1'b1;
        tick();
        check("stall resume", tx_data, 8'h4E);
        #2 reset = 1'b1;
        #1 check_all_zero("reset midframe");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no resend start", {7'd0, tx_start}, 8'h00);
            check("no resend busy", {7'd0, busy}, 8'h00);
        end
        check("post reset online", {7'd0, online}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
